// File: rtl/fib_sched.sv
// fib_sched: round-robin scheduler sharing one fibonacci engine among N_REQ
// requesters. The engine latches its result until reset, so the scheduler
// owns the engine reset and pulses it after every launched job.
// Optional watchdog in WAIT: define FIB_SCHED_TIMEOUT_EN.
module fib_sched #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ*16-1:0]  req_n,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_err,
  output logic [15:0]          eng_din,
  output logic                 eng_start,
  output logic                 eng_reset,
  input  logic [15:0]          eng_dout,
  input  logic                 eng_done
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fib_sched: N_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state_q;
  logic [IDW-1:0]   last_q;
  logic [IDW-1:0]   id_q;
  logic [15:0]      n_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [15:0]      rsp_data_q;
  logic [15:0]      eng_din_q;
  logic             eng_start_q;
  logic             eng_reset_q;

  logic [15:0]      req_n_a [N_REQ];
  logic             grant_vld;
  logic [IDW-1:0]   grant_id;
  logic [15:0]      grant_n;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_n_a[i] = req_n[16*i +: 16];
  end

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    grant_n   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = (32'(last_q) + 1 + k) % N_REQ;
      if (!grant_vld && req_valid[IDW'(idx)]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(idx);
        grant_n   = req_n_a[IDW'(idx)];
      end
    end
  end

  // req_ready must answer within the IDLE cycle it is requested in, so it is
  // decoded from state and inputs rather than registered; held low in reset.
  assign req_ready = (state_q == S_IDLE && grant_vld && reset_n) ? (ONE << grant_id) : '0;

`ifdef FIB_SCHED_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WDW-1:0] wd_q;
  logic           rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Scheduler FSM; outputs are registered on the transition into each state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      last_q      <= IDW'(N_REQ - 1);
      id_q        <= '0;
      n_q         <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      eng_din_q   <= '0;
      eng_start_q <= 1'b0;
      eng_reset_q <= 1'b1;
`ifdef FIB_SCHED_TIMEOUT_EN
      wd_q        <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      eng_din_q   <= '0;
      eng_start_q <= 1'b0;
      eng_reset_q <= 1'b0;
`ifdef FIB_SCHED_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (grant_vld) begin
            last_q <= grant_id;
            id_q   <= grant_id;
            n_q    <= grant_n;
            if (grant_n == 16'd0) begin
              // F(0) needs no engine run: answer directly, no engine reset.
              state_q     <= S_RESP;
              rsp_valid_q <= ONE << grant_id;
            end else begin
              state_q     <= S_LAUNCH;
              eng_start_q <= 1'b1;
              eng_din_q   <= grant_n;
            end
          end
        end
        S_LAUNCH: begin
          // eng_done is deliberately ignored here.
          state_q   <= S_WAIT;
          eng_din_q <= n_q;
`ifdef FIB_SCHED_TIMEOUT_EN
          wd_q      <= '0;
`endif
        end
        S_WAIT: begin
          if (eng_done) begin
            state_q     <= S_RESP;
            rsp_valid_q <= ONE << id_q;
            rsp_data_q  <= eng_dout;
            eng_reset_q <= 1'b1;
          end
`ifdef FIB_SCHED_TIMEOUT_EN
          else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
            state_q     <= S_RESP;
            rsp_valid_q <= ONE << id_q;
            rsp_err_q   <= 1'b1;
            eng_reset_q <= 1'b1;
          end else begin
            wd_q      <= wd_q + 1'b1;
            eng_din_q <= n_q;
          end
`else
          else begin
            eng_din_q <= n_q;
          end
`endif
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign eng_din   = eng_din_q;
  assign eng_start = eng_start_q;
  assign eng_reset = eng_reset_q;

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched with a behavioural fibonacci engine attached.
module tb_fib_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [63:0] req_n;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] eng_din;
  logic        eng_start;
  logic        eng_reset;
  logic [15:0] eng_dout = '0;
  logic        eng_done = 1'b0;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  int rst_cnt   = 0;
  int rsp_cnt   = 0;
  int snap_a, snap_b;

  fib_sched #(.N_REQ(4), .TIMEOUT_CYCLES(1024)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_n     (req_n),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .eng_din   (eng_din),
    .eng_start (eng_start),
    .eng_reset (eng_reset),
    .eng_dout  (eng_dout),
    .eng_done  (eng_done)
  );

  always #5 clk = ~clk;

  // Engine: after start, counts n cycles comparing against din each cycle,
  // then holds done/dout (F(1)=F(2)=1, mod 2^16) until reset.
  logic        e_busy = 1'b0;
  logic [15:0] e_cnt = '0, e_a = '0, e_b = '0;
  always @(posedge clk) begin
    if (eng_reset) begin
      e_busy <= 1'b0; eng_done <= 1'b0; eng_dout <= '0;
      e_cnt <= '0; e_a <= '0; e_b <= '0;
    end else if (e_busy) begin
      if (e_cnt + 16'd1 == eng_din) begin
        eng_done <= 1'b1; eng_dout <= e_b; e_busy <= 1'b0;
      end else begin
        e_a <= e_b; e_b <= e_a + e_b; e_cnt <= e_cnt + 16'd1;
      end
    end else if (!eng_done && eng_start) begin
      e_busy <= 1'b1; e_cnt <= '0; e_a <= '0; e_b <= 16'd1;
    end
  end

  // Pulse counters for checks that something never happened.
  always @(posedge clk) begin
    if (eng_start) start_cnt <= start_cnt + 1;
    if (eng_reset) rst_cnt <= rst_cnt + 1;
    if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One job from an IDLE cycle: accept now, response at n+3 (or 1 for n==0).
  task automatic run_job(input int id, input logic [15:0] n, input logic [15:0] exp, input string tag);
    req_valid[id] = 1'b1;
    req_n[16*id +: 16] = n;
    #1 chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    tick();
    req_valid[id] = 1'b0;
    if (n != 16'd0) begin
      repeat (int'(n) + 1) tick();
      chk({tag, "_early_rsp"}, 32'(rsp_valid), 32'd0);
      tick();
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(1) << id);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'(exp));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_eng_reset"}, 32'(eng_reset), (n != 16'd0) ? 32'd1 : 32'd0);
    tick();
  endtask

  initial begin
    reset_n = 1'b1;
    req_valid = '0;
    req_n = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_eng_din", 32'(eng_din), 32'd0);
    chk("rst_eng_start", 32'(eng_start), 32'd0);
    chk("rst_eng_reset", 32'(eng_reset), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("rel_eng_reset_held", 32'(eng_reset), 32'd1);

    // Single request, requester 2, n=10, accepted in the first post-reset cycle.
    req_valid[2] = 1'b1;
    req_n[47:32] = 16'd10;
    #1 chk("single_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    chk("single_eng_reset_fell", 32'(eng_reset), 32'd0);
    chk("single_eng_start", 32'(eng_start), 32'd1);
    chk("single_eng_din_launch", 32'(eng_din), 32'd10);
    repeat (11) tick();
    chk("single_wait_no_rsp", 32'(rsp_valid), 32'd0);
    chk("single_wait_din", 32'(eng_din), 32'd10);
    chk("single_wait_no_start", 32'(eng_start), 32'd0);
    tick();
    chk("single_rsp_valid", 32'(rsp_valid), 32'b0100);
    chk("single_rsp_data", 32'(rsp_data), 32'd55);
    chk("single_rsp_err", 32'(rsp_err), 32'd0);
    chk("single_eng_reset", 32'(eng_reset), 32'd1);
    chk("single_resp_din", 32'(eng_din), 32'd0);
    tick();
    chk("single_after_valid", 32'(rsp_valid), 32'd0);
    chk("single_after_data", 32'(rsp_data), 32'd0);
    chk("single_after_eng_reset", 32'(eng_reset), 32'd0);

    // Zero index: direct answer, no engine activity; next accept right after.
    snap_a = start_cnt;
    snap_b = rst_cnt;
    run_job(3, 16'd0, 16'd0, "zero");
    chk("zero_no_start", 32'(start_cnt), 32'(snap_a));
    chk("zero_no_eng_reset", 32'(rst_cnt), 32'(snap_b));

    run_job(1, 16'd24, 16'd46368, "n24");
    run_job(0, 16'd25, 16'd9489, "n25");

    // Reset during WAIT of an n=20 job.
    req_valid[2] = 1'b1;
    req_n[47:32] = 16'd20;
    #1 chk("midrst_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    repeat (6) tick();
    chk("midrst_in_wait_din", 32'(eng_din), 32'd20);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    chk("midrst_eng_din", 32'(eng_din), 32'd0);
    chk("midrst_eng_start", 32'(eng_start), 32'd0);
    chk("midrst_eng_reset", 32'(eng_reset), 32'd1);
    repeat (2) tick();
    @(negedge clk) reset_n = 1'b1;
    snap_a = rsp_cnt;
    repeat (30) tick();
    chk("midrst_no_stale_rsp", 32'(rsp_cnt), 32'(snap_a));
    run_job(2, 16'd5, 16'd5, "fresh5");

    // Round-robin: all four request n=1 while in reset.
    reset_n = 1'b0;
    req_valid = 4'b1111;
    req_n = {4{16'd1}};
    #1 chk("rr_ready_in_reset", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1 chk($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(1) << g);
      tick();
      req_valid[g] = 1'b0;
      repeat (2) tick();
      chk($sformatf("rr_early%0d", g), 32'(rsp_valid), 32'd0);
      tick();
      chk($sformatf("rr_rsp_valid%0d", g), 32'(rsp_valid), 32'(1) << g);
      chk($sformatf("rr_rsp_data%0d", g), 32'(rsp_data), 32'd1);
      tick();
    end

`ifdef FIB_SCHED_TIMEOUT_EN
    // Watchdog: 1024 WAIT cycles then error response.
    req_valid[0] = 1'b1;
    req_n[15:0] = 16'd30000;
    #1 chk("to_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid[0] = 1'b0;
    repeat (1024) tick();
    chk("to_early", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_rsp_valid", 32'(rsp_valid), 32'b0001);
    chk("to_rsp_err", 32'(rsp_err), 32'd1);
    chk("to_rsp_data", 32'(rsp_data), 32'd0);
    chk("to_eng_reset", 32'(eng_reset), 32'd1);
    tick();
    run_job(1, 16'd3, 16'd2, "after_to");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
